// File: rtl/spike_decoder.sv
// Spike-count decoder: counts output-layer spikes on two neurons over a programmable
// window and reports the winning class through a valid/ready handshake.
module spike_decoder #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             neuron_7,
    input  logic             neuron_8,
    input  logic             result_ready,
    output logic             busy,
    output logic             result_valid,
    output logic [1:0]       class_out,
    output logic [CNT_W-1:0] count7,
    output logic [CNT_W-1:0] count8
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] cyc_q;
    logic [CNT_W-1:0] count7_q;
    logic [CNT_W-1:0] count8_q;
    logic [1:0]       class_q;
    logic             busy_q;
    logic             valid_q;

    logic [CNT_W-1:0] count7_d;
    logic [CNT_W-1:0] count8_d;
    logic             last_cycle_s;

    // Decision on the saturated counts: 00 none, 01 A wins, 10 B wins, 11 tie
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
        if ((a == CNT_ZERO) && (b == CNT_ZERO)) begin
            return 2'b00;
        end else if (a > b) begin
            return 2'b01;
        end else if (b > a) begin
            return 2'b10;
        end else begin
            return 2'b11;
        end
    endfunction

    // Saturating next-count values and end-of-window detection
    always_comb begin
        count7_d     = count7_q;
        count8_d     = count8_q;
        last_cycle_s = (cyc_q == (win_len_q - WIN_ONE));
        if (neuron_7 && (count7_q != CNT_MAX)) begin
            count7_d = count7_q + CNT_ONE;
        end else begin
            count7_d = count7_q;
        end
        if (neuron_8 && (count8_q != CNT_MAX)) begin
            count8_d = count8_q + CNT_ONE;
        end else begin
            count8_d = count8_q;
        end
    end

    // Control FSM with registered status and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_len_q <= WIN_ZERO;
            cyc_q     <= WIN_ZERO;
            count7_q  <= CNT_ZERO;
            count8_q  <= CNT_ZERO;
            class_q   <= 2'b00;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count7_q <= CNT_ZERO;
                        count8_q <= CNT_ZERO;
                        cyc_q    <= WIN_ZERO;
                        busy_q   <= 1'b1;
                        if (window_len != WIN_ZERO) begin
                            win_len_q <= window_len;
                            state_q   <= COUNT;
                        end else begin
                            class_q <= 2'b00;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                end
                COUNT: begin
                    count7_q <= count7_d;
                    count8_q <= count8_d;
                    cyc_q    <= cyc_q + WIN_ONE;
                    if (last_cycle_s) begin
                        class_q <= classify(count7_d, count8_d);
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // start is deliberately not looked at here, even on the handshake edge
                    if (result_ready) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign class_out    = class_q;
    assign count7       = count7_q;
    assign count8       = count8_q;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed self-checking bench for spike_decoder (WIN_W=8, CNT_W=6).
module tb_spike_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic       neuron_7 = 1'b0;
    logic       neuron_8 = 1'b0;
    logic       result_ready = 1'b0;
    logic       busy;
    logic       result_valid;
    logic [1:0] class_out;
    logic [5:0] count7;
    logic [5:0] count8;

    int checks = 0;
    int errors = 0;

    spike_decoder #(.WIN_W(8), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len),
        .neuron_7(neuron_7), .neuron_8(neuron_8), .result_ready(result_ready),
        .busy(busy), .result_valid(result_valid), .class_out(class_out),
        .count7(count7), .count8(count8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, result_valid, class_out, count7, count8} !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b class=%b c7=%0d c8=%0d, want all 0",
                     busy, result_valid, class_out, count7, count8);
        end
        #13;
        rst = 1'b0;
        tick();
    endtask

    // REQ-031 window of 4, plus idle spikes ignored afterwards
    task automatic test_window();
        logic [3:0] p7;
        logic [3:0] p8;
        p7 = 4'b1011;
        p8 = 4'b0100;
        start = 1'b1; window_len = 8'd4;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL window_start: got busy=%b valid=%b, want 1 0", busy, result_valid);
        end
        for (int i = 0; i < 4; i++) begin
            neuron_7 = p7[i];
            neuron_8 = p8[i];
            tick();
            if (i == 2) begin
                checks++;
                if (result_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL window_early_valid: got %b, want 0", result_valid);
                end
            end
        end
        neuron_7 = 1'b0; neuron_8 = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count7 !== 6'd3 || count8 !== 6'd1 || class_out !== 2'b01) begin
            errors++;
            $display("FAIL window_result: got valid=%b c7=%0d c8=%0d class=%b, want 1 3 1 01",
                     result_valid, count7, count8, class_out);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL window_handshake: got busy=%b valid=%b, want 0 0", busy, result_valid);
        end
        for (int i = 0; i < 4; i++) begin
            neuron_7 = i[0];
            neuron_8 = ~i[0];
            result_ready = 1'b1;
            tick();
        end
        neuron_7 = 1'b0; neuron_8 = 1'b0; result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || count7 !== 6'd3 || count8 !== 6'd1 || class_out !== 2'b01) begin
            errors++;
            $display("FAIL idle_retain: got busy=%b c7=%0d c8=%0d class=%b, want 0 3 1 01",
                     busy, count7, count8, class_out);
        end
    endtask

    // REQ-032 tie with backpressure; neuron toggles in HOLD must be ignored
    task automatic test_backpressure_tie();
        start = 1'b1; window_len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            neuron_7 = (i <= 2);
            neuron_8 = (i <= 2);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            neuron_7 = 1'b1; neuron_8 = 1'b1;
            checks++;
            if (result_valid !== 1'b1 || busy !== 1'b1 || count7 !== 6'd2 ||
                count8 !== 6'd2 || class_out !== 2'b11) begin
                errors++;
                $display("FAIL tie_hold_%0d: got valid=%b busy=%b c7=%0d c8=%0d class=%b, want 1 1 2 2 11",
                         i, result_valid, busy, count7, count8, class_out);
            end
            tick();
        end
        neuron_7 = 1'b0; neuron_8 = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count7 !== 6'd2 || class_out !== 2'b11) begin
            errors++;
            $display("FAIL tie_hold_last: got valid=%b c7=%0d class=%b, want 1 2 11",
                     result_valid, count7, class_out);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || class_out !== 2'b11) begin
            errors++;
            $display("FAIL tie_release: got busy=%b valid=%b class=%b, want 0 0 11",
                     busy, result_valid, class_out);
        end
    endtask

    // REQ-033 saturation of count8 over 100 samples
    task automatic test_saturation();
        start = 1'b1; window_len = 8'd100;
        tick();
        start = 1'b0;
        window_len = 8'd3;
        neuron_8 = 1'b1;
        for (int i = 1; i <= 99; i++) tick();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_edge99: got valid=%b busy=%b, want 0 1", result_valid, busy);
        end
        tick();
        neuron_8 = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count8 !== 6'd63 || count7 !== 6'd0 || class_out !== 2'b10) begin
            errors++;
            $display("FAIL sat_result: got valid=%b c7=%0d c8=%0d class=%b, want 1 0 63 10",
                     result_valid, count7, count8, class_out);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    // REQ-034 zero-length window goes straight to HOLD with cleared counts
    task automatic test_zero_window();
        start = 1'b1; window_len = 8'd0; neuron_7 = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || busy !== 1'b1 || class_out !== 2'b00 ||
            count7 !== 6'd0 || count8 !== 6'd0) begin
            errors++;
            $display("FAIL zero_window: got valid=%b busy=%b class=%b c7=%0d c8=%0d, want 1 1 00 0 0",
                     result_valid, busy, class_out, count7, count8);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        neuron_7 = 1'b0;
        checks++;
        if (busy !== 1'b0 || count7 !== 6'd0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got busy=%b c7=%0d valid=%b, want 0 0 0", busy, count7, result_valid);
        end
    endtask

    // REQ-035 / REQ-030 reset in the middle of a window, then immediate restart
    task automatic test_reset_mid();
        logic saw_valid;
        start = 1'b1; window_len = 8'd10;
        tick();
        start = 1'b0;
        neuron_7 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1 || count7 !== 6'd5) begin
            errors++;
            $display("FAIL rst_pre: got busy=%b c7=%0d, want 1 5", busy, count7);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || count7 !== 6'd0 || count8 !== 6'd0 || class_out !== 2'b00) begin
            errors++;
            $display("FAIL rst_async: got busy=%b valid=%b c7=%0d c8=%0d class=%b, want all 0",
                     busy, result_valid, count7, count8, class_out);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (result_valid) saw_valid = 1'b1;
        end
        rst = 1'b0;
        neuron_7 = 1'b0; neuron_8 = 1'b1;
        start = 1'b1; window_len = 8'd2;
        tick();
        start = 1'b0;
        if (result_valid) saw_valid = 1'b1;
        checks++;
        if (busy !== 1'b1 || saw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: got busy=%b stray_valid=%b, want 1 0", busy, saw_valid);
        end
        tick();
        tick();
        neuron_8 = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count8 !== 6'd2 || count7 !== 6'd0 || class_out !== 2'b10) begin
            errors++;
            $display("FAIL rst_fresh_result: got valid=%b c7=%0d c8=%0d class=%b, want 1 0 2 10",
                     result_valid, count7, count8, class_out);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    // REQ-036 / REQ-027 start pulses while busy are ignored
    task automatic test_start_busy();
        start = 1'b1; window_len = 8'd3;
        tick();
        start = 1'b0;
        neuron_7 = 1'b1;
        tick();
        start = 1'b1; window_len = 8'd7;
        tick();
        start = 1'b0;
        tick();
        neuron_7 = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || count7 !== 6'd3 || class_out !== 2'b01) begin
            errors++;
            $display("FAIL busy_start_count: got valid=%b c7=%0d class=%b, want 1 3 01",
                     result_valid, count7, class_out);
        end
        result_ready = 1'b1; start = 1'b1; window_len = 8'd4;
        tick();
        result_ready = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_handshake_start: got busy=%b valid=%b, want 0 0", busy, result_valid);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || count7 !== 6'd3) begin
            errors++;
            $display("FAIL busy_stays_idle: got busy=%b c7=%0d, want 0 3", busy, count7);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_backpressure_tie();
        test_saturation();
        test_zero_window();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter: WIN_W, default 8, width of the window-length input and the cycle counter.
REQ-002 Parameter: CNT_W, default 6, width of each per-neuron spike counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to begin one decode window; sampled only in IDLE.
REQ-006 window_len  input  WIN_W  number of cycles to observe; latched when start is accepted.
REQ-007 neuron_7  input  1  output-layer spike line, class A.
REQ-008 neuron_8  input  1  output-layer spike line, class B.
REQ-009 busy  output  1  high in COUNT and HOLD.
REQ-010 result_valid  output  1  high in HOLD only.
REQ-011 result_ready  input  1  consumer accepts the result.
REQ-012 class_out  output  2  decision: 00 none, 01 class A, 10 class B, 11 tie.
REQ-013 count7  output  CNT_W  spikes counted on neuron_7 in the last or current window.
REQ-014 count8  output  CNT_W  spikes counted on neuron_8 in the last or current window.

Function
REQ-015 The FSM SHALL have three states: IDLE, COUNT and HOLD.
REQ-016 In IDLE with start=1 and window_len>0, the block SHALL latch window_len, clear count7/count8 and the cycle counter, and enter COUNT.
REQ-017 In IDLE with start=1 and window_len=0, the block SHALL clear both counters and enter HOLD directly with class_out=00.
REQ-018 In COUNT, each rising edge SHALL sample neuron_7 and neuron_8 and increment the corresponding counter when the line is 1; both counters may increment on the same edge.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 Timing: if start is accepted at edge N with length L, spikes SHALL be sampled on edges N+1 through N+L inclusive (exactly L samples), and the FSM SHALL enter HOLD at edge N+L.
REQ-021 class_out SHALL be registered on entry to HOLD:
  - 00 if both counts are 0
  - 01 if count7>count8
  - 10 if count8>count7
  - 11 if the counts are equal and nonzero
  - comparison is on the saturated values
REQ-022 In HOLD, result_valid, class_out, count7 and count8 SHALL remain stable until result_valid and result_ready are both 1 on a rising edge; the FSM SHALL then return to IDLE.
REQ-023 result_ready SHALL be ignored outside HOLD.
REQ-024 start SHALL be ignored in COUNT and HOLD, including the HOLD handshake cycle; a start asserted on that cycle is not accepted.
REQ-025 Neuron inputs SHALL be ignored in IDLE and HOLD.
REQ-026 In IDLE, count7, count8 and class_out SHALL retain the last completed result.
REQ-027 window_len changes after acceptance SHALL NOT affect the running window.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, with busy=0, result_valid=0, class_out=00, count7=0, count8=0 and the cycle counter=0, regardless of current state.
REQ-029 Reset asserted mid-COUNT or mid-HOLD SHALL discard the partial or pending result; no result_valid pulse follows release.
REQ-030 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-031 Window: start with window_len=4; neuron_7=1 on 3 of the 4 sampled edges, neuron_8=1 on 1 -> result_valid at edge N+4, count7=3, count8=1, class_out=01.
REQ-032 Backpressure and tie: window_len=5, both lines high on edges 1 and 2 only, result_ready=0 for 3 cycles then 1 -> count7=count8=2, class_out=11; outputs stable through the wait; IDLE one edge after the handshake.
REQ-033 Saturation: CNT_W=6, window_len=100, neuron_8 held high, neuron_7 low -> count8=63, count7=0, class_out=10.
REQ-034 Zero window and idle spikes: start with window_len=0 -> HOLD on the next edge with class_out=00 and both counts 0; spikes toggled while in IDLE -> counts unchanged.
REQ-035 Reset mid-run: start window_len=10, assert rst at cycle 5 -> busy=0 and counts=0 immediately; no result_valid afterwards; a fresh start is accepted normally.
REQ-036 Start during busy: pulse start in COUNT and again on the HOLD handshake cycle -> neither pulse is accepted; the FSM stays in IDLE after the handshake.
